// File: rtl/flasher_pkg.sv
// flasher_pkg: scheduler state encoding plus the definitions shared with the bound flasher.
package flasher_pkg;

    localparam int LED_W = 16;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        LAUNCH,
        RUN,
        ABORT,
        GAP
    } sched_state_t;

    // Flasher phases: 0->15, 15->5, 5->10, 10->0, 0->5, 5->0.
    typedef enum logic [2:0] {
        FL_IDLE,
        FL_UP_TO_15,
        FL_DOWN_TO_5,
        FL_UP_TO_10,
        FL_DOWN_TO_0,
        FL_UP_TO_5,
        FL_DOWN_END
    } flasher_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first pending requester after pointer.
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int IDW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] pending,
    input  logic [IDW-1:0]   pointer,
    output logic [N_REQ-1:0] winner,
    output logic [IDW-1:0]   winner_idx,
    output logic             any
);

    logic [IDW-1:0] cand;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        cand       = '0;
        // Walk lowest priority first so the nearest requester after pointer is written last.
        for (int i = N_REQ; i >= 1; i--) begin
            cand = IDW'((int'(pointer) + i) % N_REQ);
            if (pending[cand]) begin
                winner       = '0;
                winner[cand] = 1'b1;
                winner_idx   = cand;
            end
        end
        any = |pending;
    end

endmodule

// File: rtl/flick_scheduler.sv
// flick_scheduler: time-shares one bound flasher between N_REQ requesters (round-robin).
// Build option FLICK_SCHED_RETRIG_EN: owner req during RUN retriggers flick instead of queueing.
module flick_scheduler
    import flasher_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int INIT_CYCLES = 2,
    parameter int PULSE_LEN   = 1,
    parameter int IDLE_HOLD   = 4,
    parameter int MAX_RUN     = 255,
    parameter int GAP_CYCLES  = 2,
    localparam int IDW = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [LED_W-1:0] led,
    output logic             fl_reset_n,
    output logic             flick,
    output logic             busy,
    output logic [IDW-1:0]   grant_id,
    output logic             done,
    output logic [IDW-1:0]   done_id,
    output logic             aborted
);

    localparam int IW = $clog2(INIT_CYCLES + 1);
    localparam int PW = $clog2(PULSE_LEN + 1);
    localparam int ZW = $clog2(IDLE_HOLD + 1);
    localparam int RW = $clog2(MAX_RUN + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    sched_state_t     state, state_nxt;
    logic [N_REQ-1:0] pending, pending_nxt, grant_clear, req_keep;
    logic [IDW-1:0]   pointer, pointer_nxt;
    logic [IW-1:0]    init_cnt, init_nxt;
    logic [PW-1:0]    pulse_cnt, pulse_nxt;
    logic [ZW-1:0]    zero_cnt, zero_nxt;
    logic [RW-1:0]    run_cnt, run_nxt;
    logic [GW-1:0]    gap_cnt, gap_nxt;
    logic [N_REQ-1:0] win_oh;
    logic [IDW-1:0]   win_idx, grant_id_nxt, done_id_nxt;
    logic             win_any, retrig;
    logic             fl_reset_n_nxt, flick_nxt, busy_nxt, done_nxt, aborted_nxt;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .pending   (pending),
        .pointer   (pointer),
        .winner    (win_oh),
        .winner_idx(win_idx),
        .any       (win_any)
    );

    // req and done are single-cycle pulses with no back-pressure: a req is never dropped,
    // it merges into pending; done_id and aborted are meaningful only while done is high.
    always_comb begin
        state_nxt    = state;
        init_nxt     = init_cnt;
        pulse_nxt    = pulse_cnt;
        zero_nxt     = zero_cnt;
        run_nxt      = run_cnt;
        gap_nxt      = gap_cnt;
        pointer_nxt  = pointer;
        grant_id_nxt = grant_id;
        done_id_nxt  = done_id;
        grant_clear  = '0;
        req_keep     = req;
        retrig       = 1'b0;
        done_nxt     = 1'b0;
        aborted_nxt  = 1'b0;

        case (state)
            INIT: begin
                if (init_cnt == IW'(INIT_CYCLES - 1)) state_nxt = IDLE;
                else init_nxt = init_cnt + 1'b1;
            end
            IDLE: begin
                if (win_any) begin
                    state_nxt    = LAUNCH;
                    grant_clear  = win_oh;
                    grant_id_nxt = win_idx;
                    pointer_nxt  = win_idx;
                    pulse_nxt    = '0;
                    zero_nxt     = '0;
                    run_nxt      = '0;
                end
            end
            LAUNCH: begin
                if (pulse_cnt == PW'(PULSE_LEN - 1)) state_nxt = RUN;
                else pulse_nxt = pulse_cnt + 1'b1;
            end
            RUN: begin
                if (led != '0) zero_nxt = '0;
                else if (zero_cnt != ZW'(IDLE_HOLD)) zero_nxt = zero_cnt + 1'b1;
                if (run_cnt != RW'(MAX_RUN)) run_nxt = run_cnt + 1'b1;
                // Normal completion is checked first so it wins a same-cycle timeout.
                if (zero_nxt == ZW'(IDLE_HOLD)) begin
                    state_nxt   = GAP;
                    gap_nxt     = '0;
                    done_nxt    = 1'b1;
                    done_id_nxt = grant_id;
                end else if (run_nxt == RW'(MAX_RUN)) begin
                    state_nxt   = ABORT;
                    done_nxt    = 1'b1;
                    aborted_nxt = 1'b1;
                    done_id_nxt = grant_id;
                end
`ifdef FLICK_SCHED_RETRIG_EN
                if (req[grant_id]) begin
                    req_keep[grant_id] = 1'b0;
                    retrig             = (state_nxt == RUN);
                end
`endif
            end
            ABORT: begin
                state_nxt = GAP;
                gap_nxt   = '0;
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nxt = IDLE;
                else gap_nxt = gap_cnt + 1'b1;
            end
            default: state_nxt = INIT;
        endcase

        pending_nxt    = (pending & ~grant_clear) | req_keep;
        fl_reset_n_nxt = !(state_nxt == INIT || state_nxt == ABORT);
        flick_nxt      = (state_nxt == LAUNCH) || retrig;
        busy_nxt       = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= INIT;
            pending    <= '0;
            pointer    <= IDW'(N_REQ - 1);
            init_cnt   <= '0;
            pulse_cnt  <= '0;
            zero_cnt   <= '0;
            run_cnt    <= '0;
            gap_cnt    <= '0;
            fl_reset_n <= 1'b0;
            flick      <= 1'b0;
            busy       <= 1'b1;
            grant_id   <= '0;
            done       <= 1'b0;
            done_id    <= '0;
            aborted    <= 1'b0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            pointer    <= pointer_nxt;
            init_cnt   <= init_nxt;
            pulse_cnt  <= pulse_nxt;
            zero_cnt   <= zero_nxt;
            run_cnt    <= run_nxt;
            gap_cnt    <= gap_nxt;
            fl_reset_n <= fl_reset_n_nxt;
            flick      <= flick_nxt;
            busy       <= busy_nxt;
            grant_id   <= grant_id_nxt;
            done       <= done_nxt;
            done_id    <= done_id_nxt;
            aborted    <= aborted_nxt;
        end
    end

endmodule

// File: tb/tb_flick_scheduler.sv
// tb_flick_scheduler: randomized scenarios checked against a run-level model of the scheduler.
module tb_flick_scheduler;

    localparam int N         = 4;
    localparam int IDW       = 2;
    localparam int IDLE_HOLD = 4;
    localparam int MAX_RUN   = 255;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [15:0]    led;
    logic           fl_reset_n, flick, busy, done, aborted;
    logic [IDW-1:0] grant_id, done_id;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: requests waiting for service and the most recent owner.
    logic [N-1:0] pend;
    int           ptr;

    flick_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .led       (led),
        .fl_reset_n(fl_reset_n),
        .flick     (flick),
        .busy      (busy),
        .grant_id  (grant_id),
        .done      (done),
        .done_id   (done_id),
        .aborted   (aborted)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of inputs at a falling edge, return at the next falling edge.
    task automatic step(input logic [N-1:0] r, input logic [15:0] l);
        req  = r;
        led  = l;
        pend = pend | r;
        @(negedge clk);
    endtask

    function automatic int model_pick();
        for (int k = 1; k <= N; k++)
            if (pend[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    // mode 0: random bursts/short zero gaps, 1: hung LED, 2: completion on the timeout cycle,
    // 3: explicit two-cycle turn point.
    task automatic serve_run(input int mode, input bit inject, input logic [N-1:0] grant_req,
                             output int got_id);
        logic [15:0] led_q[$];
        logic [N-1:0] r;
        int exp_id, zc, comp, exp_end, gap_busy;
        bit exp_abort, exp_busy;
        got_id = -1;
        exp_id = model_pick();
        n_checks++;
        if (exp_id < 0) begin
            n_fail++;
            $display("FAIL serve_setup: model has no pending request");
            return;
        end
        pend[exp_id] = 1'b0;
        ptr = exp_id;

        step(grant_req, 16'h0);
        got_id = int'(grant_id);
        n_checks++;
        if (flick !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL grant_flick: flick=%b busy=%b required 1/1", flick, busy);
        end
        n_checks++;
        if (grant_id !== IDW'(exp_id)) begin
            n_fail++;
            $display("FAIL grant_id: got %0d required %0d", grant_id, exp_id);
        end

        step('0, 16'($urandom_range(1, 16'hFFFF)));
        n_checks++;
        if (flick !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flick_len: flick=%b busy=%b required 0/1", flick, busy);
        end

        case (mode)
            0: begin
                repeat ($urandom_range(1, 4)) begin
                    repeat ($urandom_range(1, 8)) led_q.push_back(16'($urandom_range(1, 16'hFFFF)));
                    repeat ($urandom_range(1, IDLE_HOLD - 1)) led_q.push_back(16'h0);
                end
                repeat (IDLE_HOLD) led_q.push_back(16'h0);
            end
            1: repeat (MAX_RUN + 20) led_q.push_back(16'h003F);
            2: begin
                repeat (MAX_RUN - IDLE_HOLD) led_q.push_back(16'($urandom_range(1, 16'hFFFF)));
                repeat (IDLE_HOLD) led_q.push_back(16'h0);
            end
            default: begin
                repeat (3) led_q.push_back(16'h0007);
                repeat (2) led_q.push_back(16'h0000);
                repeat (3) led_q.push_back(16'h0003);
                repeat (IDLE_HOLD) led_q.push_back(16'h0000);
            end
        endcase

        // Run ends on the first IDLE_HOLD-long zero stretch, or is aborted at MAX_RUN.
        zc = 0;
        comp = 0;
        for (int i = 0; i < led_q.size(); i++) begin
            zc = (led_q[i] == 16'h0) ? zc + 1 : 0;
            if (zc == IDLE_HOLD && comp == 0) comp = i + 1;
        end
        exp_abort = !(comp != 0 && comp <= MAX_RUN);
        exp_end   = exp_abort ? MAX_RUN : comp;

        for (int i = 1; i <= exp_end; i++) begin
            r = '0;
            if (inject && $urandom_range(0, 5) == 0) r = N'($urandom_range(1, (1 << N) - 1));
`ifdef FLICK_SCHED_RETRIG_EN
            r[exp_id] = 1'b0;
`endif
            step(r, led_q[i-1]);
            n_checks++;
            if (i < exp_end) begin
                if (done !== 1'b0 || fl_reset_n !== 1'b1) begin
                    n_fail++;
                    $display("FAIL run_cycle_%0d: done=%b fl_reset_n=%b required 0/1", i, done, fl_reset_n);
                end
            end else begin
                if (done !== 1'b1 || done_id !== IDW'(exp_id) || aborted !== exp_abort ||
                    fl_reset_n !== !exp_abort) begin
                    n_fail++;
                    $display("FAIL run_end_%0d: done=%b done_id=%0d aborted=%b fl_reset_n=%b required 1/%0d/%b/%b",
                             i, done, done_id, aborted, fl_reset_n, exp_id, exp_abort, !exp_abort);
                end
            end
        end

        gap_busy = exp_abort ? 2 : 1;
        for (int g = 0; g <= gap_busy; g++) begin
            step('0, 16'h0);
            exp_busy = (g < gap_busy);
            n_checks++;
            if (busy !== exp_busy || done !== 1'b0 || flick !== 1'b0 || fl_reset_n !== 1'b1) begin
                n_fail++;
                $display("FAIL gap_%0d: busy=%b done=%b flick=%b fl_reset_n=%b required %b/0/0/1",
                         g, busy, done, flick, fl_reset_n, exp_busy);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if ({fl_reset_n, flick, busy, grant_id, done, done_id, aborted} !== 9'b0_0_1_00_0_00_0) begin
            n_fail++;
            $display("FAIL %s: {rstn,flick,busy,gid,done,did,abort}=%b required 001000000", tag,
                     {fl_reset_n, flick, busy, grant_id, done, done_id, aborted});
        end
    endtask

    task automatic test_reset();
        req = '0;
        led = '0;
        pend = '0;
        ptr = N - 1;
        #2 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_reset_values("reset_hold");
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (fl_reset_n !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL init_c1: fl_reset_n=%b busy=%b required 0/1", fl_reset_n, busy);
        end
        @(negedge clk);
        n_checks++;
        if (fl_reset_n !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL init_c2: fl_reset_n=%b busy=%b required 0/1", fl_reset_n, busy);
        end
        @(negedge clk);
        n_checks++;
        if (fl_reset_n !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL init_c3: fl_reset_n=%b busy=%b required 1/0", fl_reset_n, busy);
        end
        repeat (4) begin
            step('0, 16'($urandom_range(0, 16'hFFFF)));
            n_checks++;
            if (flick !== 1'b0 || busy !== 1'b0 || fl_reset_n !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_quiet: flick=%b busy=%b fl_reset_n=%b done=%b required 0/0/1/0",
                         flick, busy, fl_reset_n, done);
            end
        end
    endtask

    task automatic test_round_robin();
        int got;
        int exp_order[3];
        exp_order[0] = 0;
        exp_order[1] = 1;
        exp_order[2] = 3;
        step(4'b1011, 16'h0);
        n_checks++;
        if (busy !== 1'b0 || flick !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_latency: busy=%b flick=%b required 0/0", busy, flick);
        end
        for (int k = 0; k < 3; k++) begin
            serve_run(0, 1'b0, '0, got);
            n_checks++;
            if (got != exp_order[k]) begin
                n_fail++;
                $display("FAIL rr_order_%0d: got %0d required %0d", k, got, exp_order[k]);
            end
        end
        repeat (3) begin
            step('0, 16'h0);
            n_checks++;
            if (busy !== 1'b0 || flick !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_once: busy=%b flick=%b required 0/0", busy, flick);
            end
        end
    endtask

    task automatic test_single_run();
        int got;
        step(4'b0010, 16'h0);
        n_checks++;
        if (busy !== 1'b0 || flick !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency: busy=%b flick=%b required 0/0", busy, flick);
        end
        serve_run(0, 1'b0, '0, got);
        n_checks++;
        if (got != 1) begin
            n_fail++;
            $display("FAIL single_owner: got %0d required 1", got);
        end
    endtask

    task automatic test_requeue();
        int got;
        step(4'b0010, 16'h0);
        serve_run(0, 1'b0, 4'b0010, got);
        serve_run(0, 1'b0, '0, got);
        n_checks++;
        if (got != 1) begin
            n_fail++;
            $display("FAIL requeue_owner: got %0d required 1", got);
        end
        step('0, 16'h0);
        n_checks++;
        if (busy !== 1'b0 || flick !== 1'b0) begin
            n_fail++;
            $display("FAIL requeue_once: busy=%b flick=%b required 0/0", busy, flick);
        end
    endtask

    task automatic test_turn_point();
        int got;
        step(4'b0100, 16'h0);
        serve_run(3, 1'b0, '0, got);
    endtask

    task automatic test_timeout();
        int got;
        step(4'b1000, 16'h0);
        serve_run(1, 1'b0, '0, got);
    endtask

    task automatic test_timeout_tie();
        int got;
        step(4'b0001, 16'h0);
        serve_run(2, 1'b0, '0, got);
    endtask

    task automatic test_random();
        int got, guard;
        logic [N-1:0] g_req;
        repeat (8) begin
            if (pend == '0) step(N'($urandom_range(1, (1 << N) - 1)), 16'h0);
            g_req = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
            serve_run(0, 1'b1, g_req, got);
        end
        guard = 0;
        while (pend != '0 && guard < 20) begin
            serve_run(0, 1'b0, '0, got);
            guard++;
        end
    endtask

    task automatic test_reset_mid_run();
        int got;
        step(4'b0001, 16'h0);
        pend[0] = 1'b0;
        ptr = 0;
        step('0, 16'h0);
        n_checks++;
        if (flick !== 1'b1 || grant_id !== IDW'(0)) begin
            n_fail++;
            $display("FAIL mid_grant: flick=%b grant_id=%0d required 1/0", flick, grant_id);
        end
        step('0, 16'h0011);
        step(4'b0100, 16'h00FF);
        step('0, 16'h00FF);
        reset = 1'b0;
        #1;
        check_reset_values("mid_reset_async");
        @(negedge clk);
        check_reset_values("mid_reset_hold");
        reset = 1'b1;
        pend = '0;
        ptr = N - 1;
        repeat (8) begin
            step('0, 16'h0);
            n_checks++;
            if (flick !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_no_grant: flick=%b done=%b required 0/0", flick, done);
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_idle: busy=%b required 0", busy);
        end
        step(4'b1000, 16'h0);
        serve_run(0, 1'b0, '0, got);
        n_checks++;
        if (got != 3) begin
            n_fail++;
            $display("FAIL mid_pointer: got %0d required 3", got);
        end
    endtask

    initial begin
        reset = 1'b1;
        req = '0;
        led = '0;
        test_reset();
        test_round_robin();
        test_single_run();
        test_requeue();
        test_turn_point();
        test_timeout();
        test_timeout_tie();
        test_random();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
